// File: rtl/instr_fetch_unit.sv
// PC sequencer + fetch queue feeding decode; optional range/alignment check under IFETCH_ADDR_CHECK_EN.
// Latency: a word sampled at edge N is presented on out_* after edge N (one cycle through the queue).
// Backpressure: decode stalls via out_ready; a full queue holds the PC, and a same-cycle pop lets a push proceed.
module instr_fetch_unit #(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int unsigned FQ_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instru,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    fq_entry_t          fq_q [FQ_DEPTH];
    fq_entry_t          fq_d [FQ_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               pop;
    logic               push;
    logic               has_space;
    logic               fetch_ok;
    logic [31:0]        redirect_target;
    state_t             resume_state;

    // Head-of-queue presentation and handshake qualifiers
    always_comb begin
        out_valid       = (count_q != '0);
        out_pc          = out_valid ? fq_q[head_q].pc    : 32'h0;
        out_instr       = out_valid ? fq_q[head_q].instr : 32'h0;
        imem_addr       = pc_q;
        pop             = out_valid && out_ready;
        has_space       = (count_q < CNT_W'(FQ_DEPTH)) || pop;
        fetch_ok        = (state_q == ST_RUN) && !redirect_valid && has_space;
        redirect_target = {redirect_pc[31:2], 2'b00};
        resume_state    = halt_req ? ST_HALT : ST_RUN;
    end

`ifdef IFETCH_ADDR_CHECK_EN
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic        range_bad;
    logic        redirect_bad;

    // Fetch-address checks: PC beyond the attached memory, or a misaligned redirect target
    always_comb begin
        range_bad    = ({2'b00, pc_q[31:2]} >= 32'(DEPTH_WORDS));
        redirect_bad = (redirect_pc[1:0] != 2'b00);
    end

    assign fault    = fault_q;
    assign fault_pc = fault_pc_q;
`else
    // The low redirect bits and the memory size only matter when the check is built in
    logic unused_cfg;
    assign unused_cfg = ^{redirect_pc[1:0], DEPTH_WORDS[0]};

    assign fault    = 1'b0;
    assign fault_pc = 32'h0;
`endif

    // Next-state logic: redirect has priority, otherwise fetch into the queue and drain the head
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fq_d    = fq_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push    = 1'b0;
`ifdef IFETCH_ADDR_CHECK_EN
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
`endif

        if (redirect_valid) begin
            // Flush drops everything, including a head being popped this cycle
            pc_d    = redirect_target;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
`ifdef IFETCH_ADDR_CHECK_EN
            if (redirect_bad) begin
                state_d    = ST_FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end else begin
                state_d    = resume_state;
                fault_d    = 1'b0;
                fault_pc_d = 32'h0;
            end
`else
            state_d = resume_state;
`endif
        end else begin
            // FAULT is only left through a legal redirect
            state_d = (state_q == ST_FAULT) ? ST_FAULT : resume_state;
`ifdef IFETCH_ADDR_CHECK_EN
            if (fetch_ok && range_bad) begin
                state_d    = ST_FAULT;
                fault_d    = 1'b1;
                fault_pc_d = pc_q;
            end else begin
                push = fetch_ok;
            end
`else
            push = fetch_ok;
`endif
            if (push) begin
                fq_d[tail_q] = '{pc: pc_q, instr: imem_instru};
                tail_d       = tail_q + PTR_W'(1);
                pc_d         = pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State, PC, queue storage and pointers; async reset clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            fq_q    <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
`ifdef IFETCH_ADDR_CHECK_EN
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fq_q    <= fq_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
`ifdef IFETCH_ADDR_CHECK_EN
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a queue-based reference model.
// Latency: expected beats are queued when the model fetches; the monitor pops them as decode accepts.
// Backpressure: out_ready, halt_req and redirects are randomized; the model applies the fetch rules directly.
module tb_instr_fetch_unit;

    localparam int FQ = 4;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instru;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt_req = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DEPTH_WORDS(DW),
        .RESET_PC   (32'h0),
        .FQ_DEPTH   (FQ)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instru   (imem_instru),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fault         (fault),
        .fault_pc      (fault_pc)
    );

    // Instruction memory: mem[i] = i+1 inside the array, ~addr outside it
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a[31:2] < 30'(DW)) return {2'b00, a[31:2]} + 32'd1;
        else                   return ~a;
    endfunction

    always_comb imem_instru = word_at(imem_addr);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    // Reference model state
    beat_t       exp_q[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_halted = 1'b0;
    bit          m_fault = 1'b0;
    logic [31:0] m_fpc = 32'h0;
    int          cnt0;
    bit          pop_m;
    beat_t       mon_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of fetch rules, applied after the monitor has consumed this cycle's pop
    task automatic model_step(input bit rv, input logic [31:0] rpc, input bit hr);
        bit do_push;
        if (rv) begin
            exp_q.delete();
            m_pc = {rpc[31:2], 2'b00};
`ifdef IFETCH_ADDR_CHECK_EN
            if (rpc[1:0] != 2'b00) begin
                m_fault = 1'b1;
                m_fpc   = rpc;
            end else begin
                m_fault = 1'b0;
                m_fpc   = 32'h0;
            end
`endif
        end else if (!m_halted && !m_fault && (cnt0 < FQ || pop_m)) begin
            do_push = 1'b1;
`ifdef IFETCH_ADDR_CHECK_EN
            if (m_pc[31:2] >= 30'(DW)) begin
                do_push = 1'b0;
                m_fault = 1'b1;
                m_fpc   = m_pc;
            end
`endif
            if (do_push) begin
                exp_q.push_back('{pc: m_pc, instr: word_at(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        m_halted = hr;
    endtask

    // Drive one cycle of inputs at the falling edge; they take effect at the next rising edge
    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc, input bit hr);
        @(negedge clk);
        rst_n          = 1'b1;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        cnt0           = exp_q.size();
        pop_m          = (cnt0 > 0) && rdy;
        #3;
        model_step(rv, rpc, hr);
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without waiting for a clock
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_pc",    out_pc,         32'h0);
        chk("rst_out_instr", out_instr,      32'h0);
        chk("rst_imem_addr", imem_addr,      32'h0);
        chk("rst_fault",     32'(fault),     32'h0);
        chk("rst_fault_pc",  fault_pc,       32'h0);
        exp_q.delete();
        m_pc     = 32'h0;
        m_halted = 1'b0;
        m_fault  = 1'b0;
        m_fpc    = 32'h0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Monitor: compare the head against the scoreboard, pop on accepted handshakes
    always @(negedge clk) begin
        #2;
        if (mon_en && rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("imem_addr", imem_addr, m_pc);
            chk("fault", 32'(fault), 32'(m_fault));
            chk("fault_pc", fault_pc, m_fpc);
            if (exp_q.size() == 0) begin
                chk("idle_out_pc", out_pc, 32'h0);
                chk("idle_out_instr", out_instr, 32'h0);
            end else if (out_ready) begin
                mon_b = exp_q.pop_front();
                chk("out_pc", out_pc, mon_b.pc);
                chk("out_instr", out_instr, mon_b.instr);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          prev_rv;
        bit          hr_lvl;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;

        do_reset();
        mon_en = 1'b1;

        // Streaming from reset: 0,4,8.. with words 1,2,3..
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Stall decode until the queue fills; PC parks at 0x10
        do_reset();
        repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("full_imem_addr", imem_addr, 32'h10);
        chk("full_out_valid", 32'(out_valid), 32'h1);
        chk("full_head_pc", out_pc, 32'h0);
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect with entries queued
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h40, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Halt with entries queued: drain, freeze, resume
        do_reset();
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect coincident with an accepted head, then a misaligned target
        repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h20, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0013, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect while halted
        repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 32'h30, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);

`ifdef IFETCH_ADDR_CHECK_EN
        // Last legal word, then a range fault; misaligned redirect; legal redirect clears
        cycle(1'b1, 1'b1, 32'h7C, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("range_fault", 32'(fault), 32'h1);
        chk("range_fault_pc", fault_pc, 32'h80);
        cycle(1'b1, 1'b1, 32'h2, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("align_fault_pc", fault_pc, 32'h2);
        cycle(1'b1, 1'b1, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("fault_cleared", 32'(fault), 32'h0);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);
`else
        // PC wrap past the top of the address space
        cycle(1'b1, 1'b1, 32'hFFFF_FFF4, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);
`endif

        // Random traffic
        prev_rv = 1'b0;
        hr_lvl  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = !prev_rv && ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = {$urandom_range(0, DW - 1), 2'b00};
                1:       rpc = $urandom;
                2:       rpc = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
                default: rpc = {$urandom_range(0, DW + 3), 2'(($urandom_range(0, 3)))};
            endcase
            if ($urandom_range(0, 19) == 0) hr_lvl = !hr_lvl;
            cycle(rdy, rv, rpc, hr_lvl);
            prev_rv = rv;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                prev_rv = 1'b0;
            end
        end

        // Drain with fetch stopped
        repeat (FQ + 3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("drain_out_valid", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
